flow_water_lights: RTL and testbench

- 8-LED running-light ("flowing water") controller.
- A single lit LED rotates around an 8-bit bus at one of four selectable speeds, in either direction.
- A push-button toggles between running and paused.
- Sits between board-level clock/reset/switches/button and the LED pins; no handshake with other blocks.

---
 rtl/flow_water_lights.sv | 97 +++++++++
 tb/tb_flow_water_lights.sv | 128 ++++++++++++
 2 files changed

// File: rtl/flow_water_lights.sv
// rtl/flow_water_lights.sv - 8-LED running-light controller with run/pause button
// Optional button debounce when FWL_BTN_DEBOUNCE_EN is defined.
module flow_water_lights #(
  parameter int DIV   = 10000,
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic [1:0] freq_set,
  input  logic       dir_set,
  output logic [7:0] led
);

  logic             sync_q1, sync_q2;
  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       led_q, led_d;
  logic [CNT_W-1:0] period_m1;
  logic             press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= button;
      sync_q2 <= sync_q1;
    end
  end

`ifdef FWL_BTN_DEBOUNCE_EN
  logic       db_level_q, db_level_d;
  logic [3:0] db_cnt_q, db_cnt_d;

  // A level change is accepted only after 16 consecutive cycles at the new value.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = 4'd0;
    press      = 1'b0;
    if (sync_q2 != db_level_q) begin
      if (db_cnt_q == 4'd15) begin
        db_level_d = sync_q2;
        press      = sync_q2;
      end else begin
        db_cnt_d = db_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_level_q <= 1'b0;
      db_cnt_q   <= 4'd0;
    end else begin
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
    end
  end
`else
  assign press = sync_q1 & ~sync_q2;
`endif

  always_comb begin
    period_m1 = (CNT_W'(DIV) << freq_set) - CNT_W'(1);
  end

  // The step decision uses the current run flag, so a press on a step edge toggles afterwards.
  always_comb begin
    run_d = press ? ~run_q : run_q;
    cnt_d = cnt_q;
    led_d = led_q;
    if (run_q) begin
      if (cnt_q >= period_m1) begin
        cnt_d = '0;
        led_d = dir_set ? {led_q[0], led_q[7:1]} : {led_q[6:0], led_q[7]};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      led_q <= 8'h01;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_flow_water_lights.sv
// tb/tb_flow_water_lights.sv - directed self-checking bench for flow_water_lights
module tb_flow_water_lights;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [1:0] freq_set;
  logic       dir_set;
  logic [7:0] led;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  flow_water_lights #(.DIV(4), .CNT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .button   (button),
    .freq_set (freq_set),
    .dir_set  (dir_set),
    .led      (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    button = 1'b1;
    @(negedge clk);
    button = 1'b0;
  endtask

  initial begin
    logic [7:0] seq [8];
    logic [7:0] rseq [5];
    seq  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    rseq = '{8'h04, 8'h02, 8'h01, 8'h80, 8'h40};
    rst = 1'b0; button = 1'b0; freq_set = 2'b10; dir_set = 1'b0;
    cyc(3);
    check("reset_led", led, 8'h01);
    rst = 1'b1;
    cyc(100);
    check("idle_after_reset", led, 8'h01);

`ifdef FWL_BTN_DEBOUNCE_EN
    freq_set = 2'b00;
    pulse();
    cyc(60);
    check("db_short_ignored", led, 8'h01);
    button = 1'b1;
    cyc(20);
    button = 1'b0;
    cyc(40);
    check("db_long_started", {7'b0, led !== 8'h01}, 8'h01);
    check("db_onehot", {7'b0, $onehot(led)}, 8'h01);
`else
    pulse();
    cyc(16);
    check("start_before_step", led, 8'h01);
    cyc(1);
    check("start_first_step", led, 8'h02);
    for (int i = 1; i < 8; i++) begin
      cyc(15);
      check($sformatf("hold_%0d", i), led, seq[i-1]);
      cyc(1);
      check($sformatf("step_%0d", i), led, seq[i]);
    end

    cyc(5);
    pulse();
    cyc(200);
    check("paused_frozen", led, 8'h01);
    pulse();
    cyc(9);
    check("resume_partial_hold", led, 8'h01);
    cyc(1);
    check("resume_partial_step", led, 8'h02);

    cyc(5);
    freq_set = 2'b00;
    cyc(1);
    check("speed_switch_immediate", led, 8'h04);
    cyc(3);
    check("fast_hold", led, 8'h04);
    cyc(1);
    check("fast_step", led, 8'h08);

    dir_set = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(4);
      check($sformatf("right_%0d", i), led, rseq[i]);
    end

    rst = 1'b0;
    #1;
    check("async_reset_mid_run", led, 8'h01);
    @(negedge clk);
    rst = 1'b1;
    cyc(50);
    check("paused_after_reset", led, 8'h01);

    button = 1'b1;
    cyc(1);
    cyc(5);
    check("held_press_first", led, 8'h80);
    cyc(12);
    check("held_press_single", led, 8'h10);
    button = 1'b0;
    cyc(2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
